// File: rtl/write_driver.sv
// write_driver: sequences SRAM wordlines and complementary bitlines through
// precharge, drive and recovery phases for one logic write request.
// Optional feature macro: WRITE_DRIVER_MASK_EN adds a per-column write mask.
module write_driver #(
    parameter int unsigned ROWS             = 16,
    parameter int unsigned COLS             = 8,
    parameter int unsigned PRECHARGE_CYCLES = 1,
    parameter int unsigned DRIVE_CYCLES     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_req,
    input  logic [$clog2(ROWS)-1:0]  wr_row,
    input  logic [COLS-1:0]          wr_data,
`ifdef WRITE_DRIVER_MASK_EN
    input  logic [COLS-1:0]          wr_mask,
`endif
    output logic                     wr_ready,
    output logic                     wr_done,
    output logic                     wr_err,
    output real                      row_wr [0:ROWS-1],
    output real                      bl_wr  [0:COLS-1],
    output real                      blb_wr [0:COLS-1]
);

    localparam real VDD = 1.5;
    localparam real VSS = 0.0;

    localparam int unsigned ROW_W   = $clog2(ROWS);
    localparam int unsigned CNT_MAX = (PRECHARGE_CYCLES > DRIVE_CYCLES) ? PRECHARGE_CYCLES
                                                                        : DRIVE_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRECHARGE,
        S_DRIVE,
        S_RECOVER,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COLS-1:0]    data_q, data_d;
    logic [COLS-1:0]    mask_d;

    // Logic-level drive controls; registered and converted to voltages below
    logic [ROWS-1:0]    wl_q, wl_d;
    logic [COLS-1:0]    bl_lo_q, bl_lo_d;
    logic [COLS-1:0]    blb_lo_q, blb_lo_d;
    logic               ready_d, done_d, err_d;

`ifdef WRITE_DRIVER_MASK_EN
    logic [COLS-1:0]    mask_q;
`else
    assign mask_d = '1;
`endif

    // Next-state, latch capture and next-cycle drive levels
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        row_d    = row_q;
        data_d   = data_q;
`ifdef WRITE_DRIVER_MASK_EN
        mask_d   = mask_q;
`endif
        ready_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        wl_d     = '0;
        bl_lo_d  = '0;
        blb_lo_d = '0;

        case (state_q)
            S_IDLE: begin
                if (wr_req) begin
                    row_d  = wr_row;
                    data_d = wr_data;
`ifdef WRITE_DRIVER_MASK_EN
                    mask_d = wr_mask;
`endif
                    if ({1'b0, wr_row} < (ROW_W+1)'(ROWS)) begin
                        state_d = S_PRECHARGE;
                        cnt_d   = CNT_W'(PRECHARGE_CYCLES - 1);
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_PRECHARGE: begin
                if (cnt_q == '0) begin
                    state_d = S_DRIVE;
                    cnt_d   = CNT_W'(DRIVE_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DRIVE: begin
                if (cnt_q == '0) begin
                    state_d = S_RECOVER;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RECOVER: state_d = S_IDLE;
            S_ERR:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_RECOVER);
        err_d   = (state_d == S_ERR);
        if (state_d == S_DRIVE) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                wl_d[r] = (row_d == ROW_W'(r));
            end
            bl_lo_d  = ~data_d & mask_d;
            blb_lo_d =  data_d & mask_d;
        end
    end

    // State, latched request and registered output controls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            row_q    <= '0;
            data_q   <= '0;
            wl_q     <= '0;
            bl_lo_q  <= '0;
            blb_lo_q <= '0;
            wr_ready <= 1'b1;
            wr_done  <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            row_q    <= row_d;
            data_q   <= data_d;
            wl_q     <= wl_d;
            bl_lo_q  <= bl_lo_d;
            blb_lo_q <= blb_lo_d;
            wr_ready <= ready_d;
            wr_done  <= done_d;
            wr_err   <= err_d;
        end
    end

`ifdef WRITE_DRIVER_MASK_EN
    // Latched write mask
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end
`endif

    // Map registered drive controls onto supply voltages
    always_comb begin
        for (int unsigned r = 0; r < ROWS; r++) begin
            row_wr[r] = wl_q[r] ? VDD : VSS;
        end
        for (int unsigned c = 0; c < COLS; c++) begin
            bl_wr[c]  = bl_lo_q[c]  ? VSS : VDD;
            blb_wr[c] = blb_lo_q[c] ? VSS : VDD;
        end
    end

endmodule

// File: tb/tb_write_driver.sv
// tb_write_driver: randomized and directed checks of two write_driver
// instances (defaults, and ROWS=12/PRECHARGE=3/DRIVE=4) against a
// timeline model derived from the phase durations.
module tb_write_driver;

    localparam real VDD = 1.5;
    localparam real VSS = 0.0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_req = 1'b0;
    logic [3:0] wr_row = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] wr_mask = '1;

    logic rdy0, dn0, er0, rdy1, dn1, er1;
    real  rw0 [0:15];
    real  bl0 [0:7];
    real  blb0 [0:7];
    real  rw1 [0:11];
    real  bl1 [0:7];
    real  blb1 [0:7];

    write_driver u_dut0 (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_row(wr_row), .wr_data(wr_data),
`ifdef WRITE_DRIVER_MASK_EN
        .wr_mask(wr_mask),
`endif
        .wr_ready(rdy0), .wr_done(dn0), .wr_err(er0),
        .row_wr(rw0), .bl_wr(bl0), .blb_wr(blb0)
    );

    write_driver #(.ROWS(12), .COLS(8), .PRECHARGE_CYCLES(3), .DRIVE_CYCLES(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_row(wr_row), .wr_data(wr_data),
`ifdef WRITE_DRIVER_MASK_EN
        .wr_mask(wr_mask),
`endif
        .wr_ready(rdy1), .wr_done(dn1), .wr_err(er1),
        .row_wr(rw1), .bl_wr(bl1), .blb_wr(blb1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one outstanding write per instance, described by the
    // cycle whose closing edge accepted it and the parameters of the instance.
    bit         has    [2] = '{0, 0};
    bit         is_err [2] = '{0, 0};
    int         acc    [2] = '{0, 0};
    int         mrow   [2] = '{0, 0};
    logic [7:0] mdata  [2];
    logic [7:0] mmask  [2];
    int         pc     [2] = '{1, 3};
    int         dc     [2] = '{2, 4};
    int         nr     [2] = '{16, 12};

    int done_q [$];
    int acc_cnt0 = 0;

    task automatic check(input string tag, input real got, input real exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0.2f expected %0.2f (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit exp_ready(input int i);
        int n;
        int busy_len;
        n = cyc - acc[i];
        busy_len = is_err[i] ? 1 : pc[i] + dc[i] + 1;
        return !(has[i] && n >= 1 && n <= busy_len);
    endfunction

    task automatic check_inst(input int i);
        real rw [16];
        real bl [8];
        real blb [8];
        bit  rdy, dn, er, drv;
        int  n, nhi;
        real e_bl, e_blb;
        n = cyc - acc[i];
        for (int r = 0; r < 16; r++) rw[r] = (i == 0) ? rw0[r] : ((r < 12) ? rw1[r] : VSS);
        for (int c = 0; c < 8; c++) begin
            bl[c]  = (i == 0) ? bl0[c]  : bl1[c];
            blb[c] = (i == 0) ? blb0[c] : blb1[c];
        end
        rdy = (i == 0) ? rdy0 : rdy1;
        dn  = (i == 0) ? dn0  : dn1;
        er  = (i == 0) ? er0  : er1;
        drv = has[i] && !is_err[i] && n >= pc[i] + 1 && n <= pc[i] + dc[i];

        check($sformatf("u%0d_ready", i), real'(rdy), real'(exp_ready(i)));
        check($sformatf("u%0d_done", i), real'(dn),
              real'(has[i] && !is_err[i] && n == pc[i] + dc[i] + 1));
        check($sformatf("u%0d_err", i), real'(er), real'(has[i] && is_err[i] && n == 1));
        nhi = 0;
        for (int r = 0; r < nr[i]; r++) begin
            check($sformatf("u%0d_row%0d", i, r), rw[r], (drv && r == mrow[i]) ? VDD : VSS);
            if (rw[r] == VDD) nhi++;
        end
        check($sformatf("u%0d_wl_onehot", i), real'(nhi <= 1), 1.0);
        for (int c = 0; c < 8; c++) begin
            e_bl  = VDD;
            e_blb = VDD;
            if (drv && mmask[i][c]) begin
                e_bl  = mdata[i][c] ? VDD : VSS;
                e_blb = mdata[i][c] ? VSS : VDD;
            end
            check($sformatf("u%0d_bl%0d", i, c), bl[c], e_bl);
            check($sformatf("u%0d_blb%0d", i, c), blb[c], e_blb);
            check($sformatf("u%0d_blpair%0d", i, c), real'(bl[c] == VSS && blb[c] == VSS), 0.0);
        end
    endtask

    // One cycle: check the current cycle, then present inputs for the next edge
    task automatic step(input bit req, input int row, input logic [7:0] data,
                        input logic [7:0] mask);
        @(negedge clk);
        check_inst(0);
        check_inst(1);
        if (dn0) done_q.push_back(cyc);
        wr_req  = req;
        wr_row  = 4'(row);
        wr_data = data;
        wr_mask = mask;
        for (int i = 0; i < 2; i++) begin
            if (req && rst_n && exp_ready(i)) begin
                has[i]    = 1'b1;
                acc[i]    = cyc;
                mrow[i]   = row;
                is_err[i] = (row >= nr[i]);
                mdata[i]  = data;
`ifdef WRITE_DRIVER_MASK_EN
                mmask[i]  = mask;
`else
                mmask[i]  = 8'hFF;
`endif
                if (i == 0) acc_cnt0++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, 8'h00, 8'hFF);
    endtask

    initial begin
        mdata = '{8'h00, 8'h00};
        mmask = '{8'hFF, 8'hFF};

        // Reset held: both instances idle with precharged bitlines
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Basic write: row 5, data A5
        step(1'b1, 5, 8'hA5, 8'hFF);
        idle(10);

        // Back-to-back: req held, row 0 first then row 15
        done_q.delete();
        acc_cnt0 = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, (acc_cnt0 == 0) ? 0 : 15, 8'($urandom), 8'hFF);
        end
        idle(10);
        check("b2b_two_done", real'(done_q.size() >= 2), 1.0);
        if (done_q.size() >= 2) check("b2b_gap", real'(done_q[1] - done_q[0]), 5.0);

        // Out of range on the 12-row instance
        step(1'b1, 13, 8'h3C, 8'hFF);
        idle(10);

        // Masked write: only low nibble driven when the mask is compiled in
        step(1'b1, 2, 8'h00, 8'h0F);
        idle(12);

        // Async reset in the middle of DRIVE on row 3
        step(1'b1, 3, 8'h5A, 8'hFF);
        idle(2);
        #1 rst_n = 1'b0;
        #1;
        check("rst_row3", rw0[3], VSS);
        for (int c = 0; c < 8; c++) begin
            check($sformatf("rst_bl%0d", c), bl0[c], VDD);
            check($sformatf("rst_blb%0d", c), blb0[c], VDD);
        end
        check("rst_ready", real'(rdy0), 1.0);
        check("rst_done", real'(dn0), 0.0);
        has[0] = 1'b0;
        has[1] = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(8);

        // Randomized traffic
        for (int k = 0; k < 800; k++) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
                 8'($urandom), 8'($urandom));
        end
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
